// File: rtl/spi_mem_engine.sv
// SPI mode-0 master that turns one latched 16-bit hub request into a single
// SRAM or Flash transaction, returning read data with a one-cycle ready pulse.
module spi_mem_engine #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_cs_select,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ram_cs_n,
    output logic        spi_flash_cs_n,
    output logic [2:0]  dbg_state
);

    // Handshake: mem_req is a level held by the hub until mem_ready pulses;
    // the request is latched in IDLE and a new one is only accepted after
    // mem_req has been seen low in RELEASE, so a held request cannot retrigger.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        FINISH  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [47:0] tx_sr;
    logic [15:0] rx_sr;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        is_read;
    logic        is_flash;
    logic [47:0] frame;
    logic [5:0]  last_bit;

    assign dbg_state = state;
    assign last_bit  = is_flash ? 6'd47 : 6'd39;

    // Left-aligned frame; SRAM frames are 40 bits so the low byte is padding.
    always_comb begin
        frame = 48'h0;
        if (mem_cs_select)
            frame = {8'h03, 8'h00, 4'h0, mem_addr[11:0], 16'h0000};
        else if (mem_we)
            frame = {8'h02, mem_addr, mem_wdata[7:0], mem_wdata[15:8], 8'h00};
        else
            frame = {8'h03, mem_addr, 16'h0000, 8'h00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tx_sr          <= 48'h0;
            rx_sr          <= 16'h0;
            div_cnt        <= 8'd0;
            bit_cnt        <= 6'd0;
            is_read        <= 1'b0;
            is_flash       <= 1'b0;
            mem_rdata      <= 16'h0000;
            mem_ready      <= 1'b0;
            mem_busy       <= 1'b0;
            spi_sclk       <= 1'b0;
            spi_mosi       <= 1'b0;
            spi_ram_cs_n   <= 1'b1;
            spi_flash_cs_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        is_read  <= ~mem_we;
                        is_flash <= mem_cs_select;
                        mem_busy <= 1'b1;
                        if (mem_cs_select && mem_we) begin
                            // Flash is read-only: complete without touching the bus.
                            mem_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            tx_sr    <= frame;
                            spi_mosi <= frame[47];
                            spi_sclk <= 1'b0;
                            div_cnt  <= 8'd0;
                            bit_cnt  <= 6'd0;
                            if (mem_cs_select)
                                spi_flash_cs_n <= 1'b0;
                            else
                                spi_ram_cs_n <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx_sr    <= {rx_sr[14:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == last_bit) begin
                                state <= FINISH;
                            end else begin
                                bit_cnt  <= bit_cnt + 6'd1;
                                tx_sr    <= {tx_sr[46:0], 1'b0};
                                spi_mosi <= tx_sr[46];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                FINISH: begin
                    spi_ram_cs_n   <= 1'b1;
                    spi_flash_cs_n <= 1'b1;
                    spi_mosi       <= 1'b0;
                    spi_sclk       <= 1'b0;
                    // Bytes arrive low byte first.
                    if (is_read)
                        mem_rdata <= {rx_sr[7:0], rx_sr[15:8]};
                    mem_ready <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    mem_ready <= 1'b0;
                    state     <= RELEASE;
                end
                RELEASE: begin
                    if (!mem_req) begin
                        mem_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
